dm_arbiter: RTL and testbench

Two-port arbiter sharing the single-port data memory (`dm1`, 256 x 8) between the core's load/store datapath (port 0) and the memory loader/dump engine (port 1). Grants one requester at a time with round-robin fairness and a bounded burst length, muxes address/write data onto the memory, and routes synchronous read data back with a per-port valid. Sits between `top_level` datapath and `dm1`.

---
 rtl/dm_arb_pkg.sv | 26 ++
 rtl/dm_arbiter.sv | 134 +++++++++++++
 tb/tb_dm_arbiter.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/dm_arb_pkg.sv
//------------------------------------------------------------------------------
// dm_arb_pkg : shared types and constants for the dm1 two-port arbiter.
// Revision   : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package dm_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } arb_state_t;

   typedef logic port_t;

   localparam port_t PORT_CORE = 1'b0;
   localparam port_t PORT_LOAD = 1'b1;

   function automatic arb_state_t own_state(input port_t p);
      return (p == PORT_LOAD) ? OWN1 : OWN0;
   endfunction

endpackage

`default_nettype wire

// File: rtl/dm_arbiter.sv
//------------------------------------------------------------------------------
// dm_arbiter : round-robin, burst-bounded arbiter sharing dm1 between the core
//              (port 0) and the loader/dump engine (port 1).
// Revision   : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module dm_arbiter
   import dm_arb_pkg::*;
#(
   parameter int AW        = 8,
   parameter int DW        = 8,
   parameter int MAX_BURST = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [1:0]    req,
   input  logic [1:0]    we,
   input  logic [AW-1:0] addr0,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata0,
   input  logic [DW-1:0] wdata1,
   output logic [1:0]    gnt,
   output logic [1:0]    rvalid,
   output logic [DW-1:0] rdata,
   output logic [AW-1:0] mem_addr,
   output logic          mem_we,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy
);

   localparam int C_CNT_W = $clog2(MAX_BURST) + 1;
   localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(MAX_BURST - 1);

   arb_state_t         r_state;
   arb_state_t         w_next;
   logic [C_CNT_W-1:0] r_cnt;
   logic [C_CNT_W-1:0] w_cnt_nxt;
   port_t              r_last;
   port_t              w_last_nxt;
   logic               r_rv_vld;
   port_t              r_rv_port;

   port_t              w_own;
   port_t              w_other;
   logic               w_issue;
   logic               w_burst_end;

   always_comb begin
      w_own       = (r_state == OWN1) ? PORT_LOAD : PORT_CORE;
      w_other     = ~w_own;
      w_issue     = (r_state != IDLE) && req[w_own];
      w_burst_end = (r_cnt == C_CNT_LAST);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_last    <= PORT_LOAD;
         r_rv_vld  <= 1'b0;
         r_rv_port <= PORT_CORE;
      end else begin
         r_state   <= w_next;
         r_cnt     <= w_cnt_nxt;
         r_last    <= w_last_nxt;
         r_rv_vld  <= w_issue && !we[w_own];
         r_rv_port <= w_own;
      end
   end

   always_comb begin
      w_next     = r_state;
      w_cnt_nxt  = r_cnt;
      w_last_nxt = r_last;

      case (r_state)
         IDLE: begin
            case (req)
               2'b01:   w_next = OWN0;
               2'b10:   w_next = OWN1;
               2'b11:   w_next = own_state(~r_last);
               default: w_next = IDLE;
            endcase
         end
         OWN0, OWN1: begin
            if (!req[w_own]) begin
               w_next = req[w_other] ? own_state(w_other) : IDLE;
            end else if (w_burst_end && req[w_other]) begin
               w_next = own_state(w_other);
            end
         end
         default: w_next = IDLE;
      endcase

      // A lone requester keeps ownership; its counter simply wraps.
      if (w_next != r_state) begin
         w_cnt_nxt = '0;
      end else if (w_issue) begin
         w_cnt_nxt = w_burst_end ? '0 : r_cnt + C_CNT_W'(1);
      end

      if ((w_next != r_state) && (w_next != IDLE)) begin
         w_last_nxt = (w_next == OWN1) ? PORT_LOAD : PORT_CORE;
      end
   end

   always_comb begin
      gnt       = {r_state == OWN1, r_state == OWN0};
      busy      = (r_state != IDLE);
      mem_addr  = '0;
      mem_we    = 1'b0;
      mem_wdata = '0;
      if (w_issue) begin
         mem_addr  = (w_own == PORT_LOAD) ? addr1  : addr0;
         mem_we    = we[w_own];
         mem_wdata = (w_own == PORT_LOAD) ? wdata1 : wdata0;
      end
   end

   // Read data returns to the port that issued it, independent of current grant.
   always_comb begin
      rvalid = 2'b00;
      rdata  = '0;
      if (r_rv_vld) begin
         rvalid = (r_rv_port == PORT_LOAD) ? 2'b10 : 2'b01;
         rdata  = mem_rdata;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_dm_arbiter.sv
//------------------------------------------------------------------------------
// tb_dm_arbiter : scoreboard bench for dm_arbiter with a 256x8 sync-read memory.
// Revision      : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_dm_arbiter;

   logic       clk;
   logic       reset;
   logic [1:0] req;
   logic [1:0] we;
   logic [7:0] addr0, addr1, wdata0, wdata1;
   logic [1:0] gnt, rvalid;
   logic [7:0] rdata, mem_addr, mem_wdata, mem_rdata;
   logic       mem_we, busy;

   dm_arbiter #(.AW(8), .DW(8), .MAX_BURST(4)) u_dut (
      .clk(clk), .reset(reset), .req(req), .we(we),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [7:0] tb_mem [256];
   int         wr_cnt = 0;

   always @(posedge clk) begin
      if (mem_we) begin
         tb_mem[mem_addr] <= mem_wdata;
         wr_cnt = wr_cnt + 1;
      end
      mem_rdata <= tb_mem[mem_addr];
   end

   typedef struct {
      logic       port;
      logic [7:0] data;
   } rd_exp_t;

   rd_exp_t    sb_q[$];
   logic [7:0] ref_mem [256];
   int         n_chk  = 0;
   int         n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp)
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      else
         n_pass++;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_rd(input logic port, input logic [7:0] data);
      rd_exp_t e;
      e.port = port;
      e.data = data;
      sb_q.push_back(e);
   endtask

   always @(negedge clk) begin
      if (rvalid != 2'b00) begin
         if (sb_q.size() == 0) begin
            chk("rv_unexpected", {30'd0, rvalid}, 32'd0);
         end else begin
            rd_exp_t e;
            e = sb_q.pop_front();
            chk("sb_port", {30'd0, rvalid}, e.port ? 32'd2 : 32'd1);
            chk("sb_data", {24'd0, rdata}, {24'd0, e.data});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int w0;
      logic [1:0] e_gnt;
      reset = 1'b1;
      req = 2'b00; we = 2'b00;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_gnt",    {30'd0, gnt},    32'd0);
      chk("rst_rvalid", {30'd0, rvalid}, 32'd0);
      chk("rst_rdata",  {24'd0, rdata},  32'd0);
      chk("rst_busy",   {31'd0, busy},   32'd0);
      chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
      chk("rst_maddr",  {24'd0, mem_addr}, 32'd0);
      step(); reset = 1'b0;

      // Port 1 alone writes F0/CC to addresses 0/1.
      step(); req = 2'b10; we = 2'b10; addr1 = 8'h00; wdata1 = 8'hF0;
      @(negedge clk); chk("t1_gnt_pre", {30'd0, gnt}, 32'd0);
      step(); ref_mem[0] = 8'hF0;
      @(negedge clk);
      chk("t1_gnt",   {30'd0, gnt}, 32'd2);
      chk("t1_we0",   {31'd0, mem_we}, 32'd1);
      chk("t1_addr0", {24'd0, mem_addr}, 32'd0);
      chk("t1_wd0",   {24'd0, mem_wdata}, 32'hF0);
      step(); addr1 = 8'h01; wdata1 = 8'hCC; ref_mem[1] = 8'hCC;
      @(negedge clk);
      chk("t1_addr1", {24'd0, mem_addr}, 32'd1);
      chk("t1_wd1",   {24'd0, mem_wdata}, 32'hCC);
      step(); req = 2'b00; we = 2'b00;
      @(negedge clk); chk("t1_we_off", {31'd0, mem_we}, 32'd0);
      step();
      @(negedge clk);
      chk("t1_idle", {30'd0, gnt}, 32'd0);
      chk("t1_busy", {31'd0, busy}, 32'd0);
      chk("t1_mem0", {24'd0, tb_mem[0]}, {24'd0, ref_mem[0]});
      chk("t1_mem1", {24'd0, tb_mem[1]}, {24'd0, ref_mem[1]});

      // Port 0 alone reads back-to-back.
      step(); req = 2'b01; we = 2'b00; addr0 = 8'h00;
      @(negedge clk); chk("t2_gnt_pre", {30'd0, gnt}, 32'd0);
      step(); push_rd(1'b0, ref_mem[0]);
      @(negedge clk); chk("t2_gnt", {30'd0, gnt}, 32'd1);
      step(); addr0 = 8'h01; push_rd(1'b0, ref_mem[1]);
      @(negedge clk); chk("t2_rv_lat", {30'd0, rvalid}, 32'd1);
      step(); req = 2'b00;
      @(negedge clk);
      step();

      // Both request after reset: port 0 first, alternate every 4 accesses.
      step(); reset = 1'b1;
      step(); reset = 1'b0;
      step(); req = 2'b11; we = 2'b10; addr0 = 8'h00; addr1 = 8'h10; wdata1 = 8'h5A;
      @(negedge clk); chk("t3_gnt_pre", {30'd0, gnt}, 32'd0);
      for (int k = 1; k <= 12; k++) begin
         step();
         addr0  = 8'(k % 2);
         addr1  = 8'(8'h10 + k);
         wdata1 = 8'(8'h5A ^ k);
         e_gnt  = ((((k - 1) / 4) % 2) == 0) ? 2'b01 : 2'b10;
         if (e_gnt == 2'b01) push_rd(1'b0, ref_mem[k % 2]);
         else                ref_mem[8'h10 + k] = wdata1;
         @(negedge clk);
         chk("t3_gnt",  {30'd0, gnt}, {30'd0, e_gnt});
         chk("t3_busy", {31'd0, busy}, 32'd1);
         if (k == 5) chk("t4_rv_handover", {30'd0, rvalid}, 32'd1);
      end
      step(); req = 2'b00; we = 2'b00;
      @(negedge clk);
      step();
      @(negedge clk);
      chk("t3_mem15", {24'd0, tb_mem[8'h15]}, {24'd0, ref_mem[8'h15]});
      chk("t3_mem18", {24'd0, tb_mem[8'h18]}, {24'd0, ref_mem[8'h18]});

      // Port 0 alone for 10 cycles: never switches.
      step(); req = 2'b01; we = 2'b00; addr0 = 8'h01;
      @(negedge clk); chk("t5_gnt_pre", {30'd0, gnt}, 32'd0);
      for (int k = 1; k <= 10; k++) begin
         step();
         addr0 = 8'(k % 2);
         push_rd(1'b0, ref_mem[k % 2]);
         @(negedge clk);
         chk("t5_gnt", {30'd0, gnt}, 32'd1);
      end
      step(); req = 2'b00;
      @(negedge clk);
      step();

      // Reset mid-burst with a read in flight and a write being issued.
      step(); req = 2'b01; we = 2'b00; addr0 = 8'h00;
      @(negedge clk);
      step();
      @(negedge clk); chk("t6_gnt", {30'd0, gnt}, 32'd1);
      step();
      w0 = wr_cnt;
      reset = 1'b1; we = 2'b01; addr0 = 8'h20; wdata0 = 8'h77;
      #1;
      chk("t6_rst_gnt",    {30'd0, gnt},    32'd0);
      chk("t6_rst_rvalid", {30'd0, rvalid}, 32'd0);
      chk("t6_rst_mem_we", {31'd0, mem_we}, 32'd0);
      chk("t6_rst_rdata",  {24'd0, rdata},  32'd0);
      step();
      step();
      chk("t6_no_write", wr_cnt, w0);
      reset = 1'b0; req = 2'b11; we = 2'b00; addr0 = 8'h01; addr1 = 8'h00;
      @(negedge clk); chk("t6_gnt_pre", {30'd0, gnt}, 32'd0);
      step(); push_rd(1'b0, ref_mem[1]);
      @(negedge clk); chk("t6_restart", {30'd0, gnt}, 32'd1);
      step(); req = 2'b00;
      @(negedge clk);
      step();
      @(negedge clk);
      chk("sb_empty", sb_q.size(), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

`default_nettype wire
